// File: rtl/gf_mat_sparvec_mul_pkg.sv
// Shared GF(2^8) constants and width derivations for the sparse matrix-vector multiplier.
// Pure definitions; no timing or flow control.
package gf_mat_sparvec_mul_pkg;

    localparam logic [8:0] GF_POLY = 9'h11B;

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int res_words(input int rows, input int n_gf);
        return (rows + n_gf - 1) / n_gf;
    endfunction

endpackage

// File: rtl/gf_mat_sparvec_mul_gf256.sv
// Combinational GF(2^8) multiply, reduced modulo x^8+x^4+x^3+x+1.
// Latency 0; no flow control.
module gf256_mul
    import gf_mat_sparvec_mul_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] a_sh;
    logic [7:0] p_acc;

    // Shift-and-add; a_sh holds a*x^i already reduced.
    always_comb begin
        a_sh  = a;
        p_acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p_acc = p_acc ^ a_sh;
            a_sh = a_sh[7] ? ({a_sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {a_sh[6:0], 1'b0};
        end
    end

    assign p = p_acc;

endmodule

// File: rtl/gf_mat_sparvec_mul.sv
// r = M*v over GF(2^8) with sparse v; VEC_WEIGHT*(RES_WORDS+2)+1 busy cycles, then o_done.
// Memories are fixed-latency (1 cycle); no backpressure, readout registered 1 cycle.
module gf_mat_sparvec_mul
    import gf_mat_sparvec_mul_pkg::*;
#(
    parameter int MAT_ROW_SIZE_BYTES = 202,
    parameter int MAT_COL_SIZE_BYTES = 278,
    parameter int VEC_SIZE_BYTES     = 278,
    parameter int VEC_WEIGHT         = 150,
    parameter int N_GF               = 8,
    localparam int PW        = 8 * N_GF,
    localparam int RES_WORDS = res_words(MAT_ROW_SIZE_BYTES, N_GF),
    localparam int POSW      = clog2_min1(VEC_SIZE_BYTES),
    localparam int MAW       = clog2_min1(MAT_COL_SIZE_BYTES * RES_WORDS),
    localparam int VAW       = clog2_min1(VEC_WEIGHT),
    localparam int RAW       = clog2_min1(RES_WORDS)
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [MAW-1:0]    o_mat_addr,
    input  logic [PW-1:0]     i_mat,
    output logic [VAW-1:0]    o_vec_addr,
    input  logic [POSW+7:0]   i_vec,
    input  logic              i_res_en,
    input  logic [RAW-1:0]    i_res_addr,
    output logic [PW-1:0]     o_res,
    output logic              o_done
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, STREAM, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [VAW-1:0]  k_q, k_d;
    logic [RAW-1:0]  w_q, w_d;
    logic [POSW-1:0] pos_q, pos_d;
    logic [7:0]      val_q, val_d;
    logic            acc_vld_q, acc_vld_d;
    logic [RAW-1:0]  acc_idx_q, acc_idx_d;
    logic [PW-1:0]   acc_q [RES_WORDS];
    logic [PW-1:0]   acc_d [RES_WORDS];
    logic [PW-1:0]   res_q, res_d;
    logic            done_q, done_d;
    logic [PW-1:0]   prod;

    for (genvar g = 0; g < N_GF; g++) begin : g_lane
        gf256_mul u_mul (
            .a (i_mat[8*g +: 8]),
            .b (val_q),
            .p (prod[8*g +: 8])
        );
    end

    assign o_mat_addr = MAW'(pos_q) * MAW'(RES_WORDS) + MAW'(w_q);
    assign o_vec_addr = k_q;
    assign o_res      = res_q;
    assign o_done     = done_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        w_d       = w_q;
        pos_d     = pos_q;
        val_d     = val_q;
        acc_vld_d = 1'b0;
        acc_idx_d = acc_idx_q;
        acc_d     = acc_q;
        res_d     = res_q;
        done_d    = 1'b0;

        // Matrix data lags its address by one cycle, so the add trails the STREAM beat.
        if (acc_vld_q) acc_d[acc_idx_q] = acc_q[acc_idx_q] ^ prod;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    for (int i = 0; i < RES_WORDS; i++) acc_d[i] = '0;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                pos_d   = i_vec[POSW+7:8];
                val_d   = i_vec[7:0];
                w_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                acc_vld_d = 1'b1;
                acc_idx_d = w_q;
                if (w_q == RAW'(RES_WORDS - 1)) begin
                    if (k_q == VAW'(VEC_WEIGHT - 1)) begin
                        state_d = FLUSH;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            FLUSH: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_res_en) res_d = (int'(i_res_addr) < RES_WORDS) ? acc_q[i_res_addr] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            w_q       <= '0;
            pos_q     <= '0;
            val_q     <= '0;
            acc_vld_q <= 1'b0;
            acc_idx_q <= '0;
            for (int i = 0; i < RES_WORDS; i++) acc_q[i] <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            w_q       <= w_d;
            pos_q     <= pos_d;
            val_q     <= val_d;
            acc_vld_q <= acc_vld_d;
            acc_idx_q <= acc_idx_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_gf_mat_sparvec_mul.sv
// Directed bench: small 8x8/weight-3 instance plus a default-size instance against a GF(256) reference.
module tb_gf_mat_sparvec_mul;

    // Small configuration: RES_WORDS=1, POSW=3, MAW=3, VAW=2, RAW=1
    localparam int SR = 1;
    localparam int SW = 3;
    // Default configuration: RES_WORDS=26, POSW=9, MAW=13, VAW=8, RAW=5
    localparam int LR = 26;
    localparam int LW = 150;
    localparam int LCOL = 278;
    localparam int LROW = 202;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_start = 1'b0, s_res_en = 1'b0, s_done;
    logic [2:0]  s_mat_addr;
    logic [63:0] s_mat_q, s_res;
    logic [1:0]  s_vec_addr;
    logic [10:0] s_vec_q;
    logic [0:0]  s_res_addr = '0;
    logic [63:0] s_mat [8];
    logic [10:0] s_vec [4];

    logic        l_start = 1'b0, l_res_en = 1'b0, l_done;
    logic [12:0] l_mat_addr;
    logic [63:0] l_mat_q, l_res;
    logic [7:0]  l_vec_addr;
    logic [16:0] l_vec_q;
    logic [4:0]  l_res_addr = '0;
    logic [63:0] l_mat [LCOL*LR];
    logic [16:0] l_vec [256];
    logic [63:0] l_ref [LR];

    always @(posedge clk) begin
        s_mat_q <= s_mat[s_mat_addr];
        s_vec_q <= s_vec[s_vec_addr];
        l_mat_q <= l_mat[l_mat_addr];
        l_vec_q <= l_vec[l_vec_addr];
    end

    gf_mat_sparvec_mul #(
        .MAT_ROW_SIZE_BYTES(8), .MAT_COL_SIZE_BYTES(8), .VEC_SIZE_BYTES(8),
        .VEC_WEIGHT(SW), .N_GF(8)
    ) u_small (
        .i_clk(clk), .i_rst(rst_n), .i_start(s_start),
        .o_mat_addr(s_mat_addr), .i_mat(s_mat_q),
        .o_vec_addr(s_vec_addr), .i_vec(s_vec_q),
        .i_res_en(s_res_en), .i_res_addr(s_res_addr),
        .o_res(s_res), .o_done(s_done)
    );

    gf_mat_sparvec_mul u_large (
        .i_clk(clk), .i_rst(rst_n), .i_start(l_start),
        .o_mat_addr(l_mat_addr), .i_mat(l_mat_q),
        .o_vec_addr(l_vec_addr), .i_vec(l_vec_q),
        .i_res_en(l_res_en), .i_res_addr(l_res_addr),
        .o_res(l_res), .o_done(l_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    task automatic set_cols_ramp();
        for (int j = 0; j < 8; j++) begin
            logic [7:0] b;
            b = 8'(j + 1);
            s_mat[j] = {8{b}};
        end
    endtask

    task automatic run_small(input int poke, output int first, output int ndone);
        first = -1;
        ndone = 0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (s_done) begin
                ndone++;
                if (first < 0) first = c;
            end
            s_start = (c == poke);
            @(posedge clk); #1;
        end
        s_start = 1'b0;
    endtask

    task automatic read_small(input logic [0:0] addr, output logic [63:0] d);
        @(posedge clk); #1 s_res_en = 1'b1; s_res_addr = addr;
        @(posedge clk); #1 s_res_en = 1'b0;
        d = s_res;
    endtask

    task automatic read_large(input logic [4:0] addr, output logic [63:0] d);
        @(posedge clk); #1 l_res_en = 1'b1; l_res_addr = addr;
        @(posedge clk); #1 l_res_en = 1'b0;
        d = l_res;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", s_done); end
        n_tests++; if (s_res !== 64'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", s_res); end
        n_tests++; if (s_mat_addr !== 3'd0) begin n_fail++; $display("FAIL reset_mat_addr got %0d want 0", s_mat_addr); end
        n_tests++; if (s_vec_addr !== 2'd0) begin n_fail++; $display("FAIL reset_vec_addr got %0d want 0", s_vec_addr); end
        rst_n = 1'b1;
        read_small(1'b0, d);
        n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_acc got %h want 0", d); end
    endtask

    task automatic test_cancel();
        int first, ndone;
        logic [63:0] d;
        set_cols_ramp();
        s_vec[0] = {3'd0, 8'h01}; s_vec[1] = {3'd1, 8'h01}; s_vec[2] = {3'd2, 8'h01};
        run_small(-1, first, ndone);
        n_tests++; if (first !== SW*(SR+2)+1) begin n_fail++; $display("FAIL cancel_latency got %0d want %0d", first, SW*(SR+2)+1); end
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL cancel_done_count got %0d want 1", ndone); end
        read_small(1'b0, d);
        n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL cancel_result got %h want 0", d); end
    endtask

    task automatic test_reduction();
        int first, ndone;
        logic [63:0] d;
        s_mat[3] = {8{8'h80}};
        s_vec[0] = {3'd3, 8'h02}; s_vec[1] = {3'd3, 8'h00}; s_vec[2] = {3'd3, 8'h00};
        run_small(-1, first, ndone);
        read_small(1'b0, d);
        n_tests++; if (d !== {8{8'h1B}}) begin n_fail++; $display("FAIL reduction got %h want %h", d, {8{8'h1B}}); end
    endtask

    task automatic test_lanes();
        int first, ndone;
        logic [63:0] d;
        s_mat[0] = 64'h0;
        s_mat[5] = 64'h0102030405060708;
        s_vec[0] = {3'd5, 8'h03}; s_vec[1] = {3'd0, 8'h00}; s_vec[2] = {3'd0, 8'h00};
        run_small(-1, first, ndone);
        read_small(1'b0, d);
        n_tests++; if (d !== 64'h0306050C0F0A0918) begin n_fail++; $display("FAIL lanes got %h want 0306050c0f0a0918", d); end
        read_small(1'b1, d);
        n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL oor_addr got %h want 0", d); end
    endtask

    task automatic test_duplicates();
        int first, ndone;
        logic [63:0] d;
        set_cols_ramp();
        // 02*05 ^ 02*07 ^ 03*01 = 0A ^ 0E ^ 03 = 07
        s_vec[0] = {3'd1, 8'h05}; s_vec[1] = {3'd1, 8'h07}; s_vec[2] = {3'd2, 8'h01};
        run_small(-1, first, ndone);
        read_small(1'b0, d);
        n_tests++; if (d !== {8{8'h07}}) begin n_fail++; $display("FAIL duplicates got %h want %h", d, {8{8'h07}}); end
    endtask

    task automatic test_reset_abort();
        int first, ndone;
        logic [63:0] d;
        s_mat[0] = 64'h0;
        s_mat[5] = 64'h0102030405060708;
        s_vec[0] = {3'd5, 8'h03}; s_vec[1] = {3'd0, 8'h00}; s_vec[2] = {3'd0, 8'h00};
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (s_res !== 64'h0) begin n_fail++; $display("FAIL abort_res got %h want 0", s_res); end
        @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (s_done) ndone++;
            @(posedge clk); #1;
        end
        n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        read_small(1'b0, d);
        n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL abort_acc_cleared got %h want 0", d); end
        run_small(-1, first, ndone);
        n_tests++; if (first !== SW*(SR+2)+1) begin n_fail++; $display("FAIL abort_rerun_latency got %0d want %0d", first, SW*(SR+2)+1); end
        read_small(1'b0, d);
        n_tests++; if (d !== 64'h0306050C0F0A0918) begin n_fail++; $display("FAIL abort_rerun got %h want 0306050c0f0a0918", d); end
    endtask

    task automatic test_start_ignored();
        int first, ndone;
        logic [63:0] d;
        set_cols_ramp();
        s_vec[0] = {3'd7, 8'h02}; s_vec[1] = {3'd4, 8'h00}; s_vec[2] = {3'd4, 8'h00};
        run_small(2, first, ndone);
        n_tests++; if (first !== SW*(SR+2)+1) begin n_fail++; $display("FAIL start_ignored_latency got %0d want %0d", first, SW*(SR+2)+1); end
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL start_ignored_done_count got %0d want 1", ndone); end
        read_small(1'b0, d);
        n_tests++; if (d !== {8{8'h10}}) begin n_fail++; $display("FAIL start_ignored_result got %h want %h", d, {8{8'h10}}); end
    endtask

    task automatic test_full_size();
        int cnt;
        logic [63:0] d;
        for (int j = 0; j < LCOL; j++) begin
            for (int w = 0; w < LR; w++) begin
                logic [63:0] m;
                m = {$urandom, $urandom};
                for (int i = 0; i < 8; i++) if (w*8 + i >= LROW) m[8*i +: 8] = 8'h00;
                l_mat[j*LR + w] = m;
            end
        end
        for (int e = 0; e < LW; e++) begin
            logic [8:0] p;
            logic [7:0] v;
            p = 9'($urandom_range(0, LCOL-1));
            v = 8'($urandom);
            if (e % 10 == 9) v = 8'h00;
            if (e == 1) p = l_vec[0][16:8];
            l_vec[e] = {p, v};
        end
        for (int w = 0; w < LR; w++) l_ref[w] = '0;
        for (int e = 0; e < LW; e++) begin
            for (int w = 0; w < LR; w++) begin
                logic [63:0] m;
                m = l_mat[int'(l_vec[e][16:8])*LR + w];
                for (int i = 0; i < 8; i++)
                    l_ref[w][8*i +: 8] = l_ref[w][8*i +: 8] ^ gmul(m[8*i +: 8], l_vec[e][7:0]);
            end
        end
        @(posedge clk); #1 l_start = 1'b1;
        @(posedge clk); #1 l_start = 1'b0;
        cnt = 0;
        while (!l_done && cnt < 5000) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_tests++; if (cnt !== LW*(LR+2)+1) begin n_fail++; $display("FAIL full_latency got %0d want %0d", cnt, LW*(LR+2)+1); end
        for (int w = 0; w < LR; w++) begin
            read_large(5'(w), d);
            n_tests++; if (d !== l_ref[w]) begin n_fail++; $display("FAIL full_word%0d got %h want %h", w, d, l_ref[w]); end
        end
        read_large(5'd30, d);
        n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL full_oor got %h want 0", d); end
    endtask

    initial begin
        for (int j = 0; j < 8; j++) s_mat[j] = '0;
        for (int e = 0; e < 4; e++) s_vec[e] = '0;
        test_reset();
        test_cancel();
        test_reduction();
        test_lanes();
        test_duplicates();
        test_reset_abort();
        test_start_ignored();
        test_full_size();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
